// File: rtl/full_adder_sync.sv
// Registered ripple-carry full adder: WIDTH chained 1-bit full-adder cells
// feeding output registers, one-cycle latency, result qualified by out_valid.

module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Classic 3-input/2-output full adder.
  always_comb begin
    s    = x ^ y ^ cin;
    cout = (x & y) | (cin & (x ^ y));
  end

endmodule

module full_adder_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // k[i] is the carry into bit i; k[WIDTH] is the carry-out.
  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] s;

  assign k[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .x    (a[i]),
      .y    (b[i]),
      .cin  (k[i]),
      .s    (s[i]),
      .cout (k[i+1])
    );
  end

  // Capture the combinational result on in_valid; reset overrides capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= s;
        carry <= k[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_adder_sync.sv
// Self-checking bench for full_adder_sync at WIDTH = 1, 4 and 8.
// An arithmetic reference model is compared every cycle; directed literal
// expectations pin the model itself.

module tb_full_adder_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       c;
  logic [0:0] a1, b1;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;

  logic       ov1, ov4, ov8;
  logic [0:0] s1;
  logic [3:0] s4;
  logic [7:0] s8;
  logic       c1, c4, c8;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state: {carry, sum} as plain sums, plus valid.
  logic       m_v;
  logic [1:0] m1;
  logic [4:0] m4;
  logic [8:0] m8;

  always #5 clk = ~clk;

  full_adder_sync #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1), .c(c),
    .out_valid(ov1), .sum(s1), .carry(c1)
  );

  full_adder_sync #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4), .c(c),
    .out_valid(ov4), .sum(s4), .carry(c4)
  );

  full_adder_sync #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8), .c(c),
    .out_valid(ov8), .sum(s8), .carry(c8)
  );

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: result is the plain unsigned sum a+b+c, held when idle.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_v = 1'b0;
      m1  = '0;
      m4  = '0;
      m8  = '0;
    end else begin
      m_v = in_valid;
      if (in_valid) begin
        m1 = 2'(a1) + 2'(b1) + 2'(c);
        m4 = 5'(a4) + 5'(b4) + 5'(c);
        m8 = 9'(a8) + 9'(b8) + 9'(c);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("w1_valid", 64'(ov1), 64'(m_v));
      cmp("w1_sum",   64'(s1),  64'(m1[0]));
      cmp("w1_carry", 64'(c1),  64'(m1[1]));
      cmp("w4_valid", 64'(ov4), 64'(m_v));
      cmp("w4_sum",   64'(s4),  64'(m4[3:0]));
      cmp("w4_carry", 64'(c4),  64'(m4[4]));
      cmp("w8_valid", 64'(ov8), 64'(m_v));
      cmp("w8_sum",   64'(s8),  64'(m8[7:0]));
      cmp("w8_carry", 64'(c8),  64'(m8[8]));
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  logic [1:0] exp_sc [8];  // {sum, carry} for (a,b,c) = 000..111

  initial begin
    exp_sc = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    rst_n = 1'b0; in_valid = 1'b0; c = 1'b0;
    a1 = '0; b1 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    tick; tick;
    chk_en = 1'b1;
    cmp("reset_valid", 64'(ov1), 64'd0);
    cmp("reset_sum",   64'(s8),  64'd0);

    // Out of reset, no valid yet: outputs stay zero.
    rst_n = 1'b1;
    tick;
    cmp("idle_valid", 64'(ov4), 64'd0);
    cmp("idle_sum",   64'({s4, c4}), 64'd0);

    // WIDTH=1 exhaustive, back-to-back.
    in_valid = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      logic [2:0] v;
      v  = 3'(i);
      a1 = v[2]; b1 = v[1]; c = v[0];
      tick;
      cmp($sformatf("w1_vec%0d", i), 64'({s1, c1}), 64'(exp_sc[i]));
      cmp($sformatf("w1_vld%0d", i), 64'(ov1), 64'd1);
    end

    // Reset wins over in_valid; inputs during reset may be unknown.
    a1 = 1'b1; b1 = 1'b1; c = 1'b1;
    tick;
    cmp("pre_rst", 64'({s1, c1}), 64'b11);
    rst_n = 1'b0;
    tick;
    cmp("rst1_out", 64'({ov1, s1, c1}), 64'd0);
    a1 = 'x; b1 = 'x; c = 'x; a4 = 'x; b4 = 'x; a8 = 'x; b8 = 'x;
    tick;
    cmp("rst2_out", 64'({ov1, s1, c1, ov8, s8, c8}), 64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    a1 = '0; b1 = '0; c = 1'b0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    tick;
    cmp("post_rst_valid", 64'(ov1), 64'd0);
    in_valid = 1'b1; a1 = 1'b1;
    tick;
    cmp("first_after_rst", 64'({ov1, s1, c1}), 64'b110);

    // Hold: capture 1+0+1, then idle with toggling inputs.
    a1 = 1'b1; b1 = 1'b0; c = 1'b1;
    tick;
    cmp("hold_cap", 64'({s1, c1}), 64'b01);
    in_valid = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      a1 = ~a1; b1 = ~b1; c = ~c;
      tick;
      cmp("hold_val", 64'({ov1, s1, c1}), 64'b001);
    end

    // WIDTH=4 carry ripple and max cases.
    in_valid = 1'b1;
    a4 = 4'hF; b4 = 4'h0; c = 1'b1; tick;
    cmp("w4_ripple", 64'({c4, s4}), 64'h10);
    a4 = 4'h7; b4 = 4'h8; c = 1'b0; tick;
    cmp("w4_7p8", 64'({c4, s4}), 64'h0F);
    a4 = 4'hF; b4 = 4'hF; c = 1'b1; tick;
    cmp("w4_max", 64'({c4, s4}), 64'h1F);
    a4 = 4'h5; b4 = 4'hA; c = 1'b1; tick;
    cmp("w4_5pA", 64'({c4, s4}), 64'h10);

    // WIDTH=8 pins.
    a8 = 8'hFF; b8 = 8'h01; c = 1'b0; tick;
    cmp("w8_wrap", 64'({c8, s8}), 64'h100);
    a8 = 8'h12; b8 = 8'h34; c = 1'b1; tick;
    cmp("w8_mid", 64'({c8, s8}), 64'h047);

    // Random traffic with random in_valid; model checks every cycle.
    for (int unsigned i = 0; i < 1000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      a1 = 1'($urandom); b1 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      tick;
    end

    in_valid = 1'b0;
    tick;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
